// File: rtl/hier_node_pkg.sv
// Shared types and default parameters for the hierarchical fan-out node.
package hier_node_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } node_state_e;

  localparam int unsigned NUM_CHILD_DEF = 5;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned MAX_OUT_DEF   = 4;

endpackage

// File: rtl/hier_credit_ctr.sv
// Per-child outstanding-command counter. It saturates at MAX_OUT and ignores
// a done that arrives at zero, flagging that done as an underflow.
module hier_credit_ctr
  import hier_node_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUT_DEF,
  localparam int unsigned CW     = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          at_max,
  output logic          at_zero,
  output logic          underflow
);

  logic [CW-1:0] count_q, count_d;
  logic          dec_eff;

  assign at_max    = (count_q == CW'(MAX_OUT));
  assign at_zero   = (count_q == '0);
  assign underflow = dec & at_zero;
  assign dec_eff   = dec & ~at_zero;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !dec_eff && !at_max) begin
      count_d = count_q + CW'(1);
    end else if (!inc && dec_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hier_fanout_node.sv
// Fan-out node: takes one upstream command at a time and dispatches it to one
// child (round-robin) or all children, tracking per-child outstanding credits.
module hier_fanout_node
  import hier_node_pkg::*;
#(
  parameter int unsigned NUM_CHILD = NUM_CHILD_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_OUT   = MAX_OUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [DATA_W-1:0]    up_data,
  input  logic                 up_bcast,
  output logic [NUM_CHILD-1:0] ch_valid,
  input  logic [NUM_CHILD-1:0] ch_ready,
  output logic [DATA_W-1:0]    ch_data,
  input  logic [NUM_CHILD-1:0] ch_done,
  output logic                 busy,
  output logic                 all_done,
  output logic                 err_underflow
);

  localparam int unsigned CW  = $clog2(MAX_OUT + 1);
  localparam int unsigned RRW = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  node_state_e state_q, state_d;

  logic [NUM_CHILD-1:0]    mask_q, mask_d;
  logic [RRW-1:0]          rr_q, rr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    busy_prev_q;
  logic                    err_q;

  logic [NUM_CHILD-1:0]    at_max, at_zero, uflow, elig, issue;
  logic [NUM_CHILD*CW-1:0] cnt_flat;
  logic [RRW-1:0]          sel_idx;
  logic                    accept;

  for (genvar g = 0; g < NUM_CHILD; g++) begin : g_ctr
    hier_credit_ctr #(.MAX_OUT(MAX_OUT)) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (issue[g]),
      .dec       (ch_done[g]),
      .count     (cnt_flat[g*CW +: CW]),
      .at_max    (at_max[g]),
      .at_zero   (at_zero[g]),
      .underflow (uflow[g])
    );
  end

  assign elig   = ~at_max;
  assign accept = up_valid & up_ready;
  assign issue  = ch_valid & ch_ready;

  // First eligible child scanning upward from the rr pointer, wrapping.
  always_comb begin
    int unsigned    cand;
    logic [RRW-1:0] cand_idx;
    logic           found;
    sel_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_CHILD; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_CHILD) cand = cand - NUM_CHILD;
      cand_idx = cand[RRW-1:0];
      if (!found && elig[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_DISPATCH;
      ST_DISPATCH: if ((mask_q & ~ch_ready) == '0) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    up_ready = 1'b0;
    ch_valid = '0;
    case (state_q)
      ST_IDLE:     up_ready = up_bcast ? (&elig) : (|elig);
      ST_DISPATCH: ch_valid = mask_q;
      default:     ;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    rr_d   = rr_q;
    data_d = data_q;
    if (accept) begin
      data_d = up_data;
      if (up_bcast) begin
        mask_d = '1;
      end else begin
        mask_d = NUM_CHILD'(1) << sel_idx;
        rr_d   = (sel_idx == RRW'(NUM_CHILD - 1)) ? '0 : sel_idx + RRW'(1);
      end
    end else if (state_q == ST_DISPATCH) begin
      mask_d = mask_q & ~ch_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      rr_q        <= '0;
      data_q      <= '0;
      busy_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      rr_q        <= rr_d;
      data_q      <= data_d;
      busy_prev_q <= busy;
      err_q       <= err_q | (|uflow);
    end
  end

  assign ch_data       = data_q;
  assign busy          = (state_q == ST_DISPATCH) | (|cnt_flat);
  // Drained when idle with every counter at zero, i.e. busy is low now.
  assign all_done      = busy_prev_q & (state_q == ST_IDLE) & (&at_zero);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_hier_fanout_node.sv
// Directed and random checks of hier_fanout_node against a cycle-level
// behavioural model of the node's dispatch and credit rules.
module tb_hier_fanout_node;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [DW-1:0] up_data = '0;
  logic          up_bcast = 1'b0;
  logic [N-1:0]  ch_valid;
  logic [N-1:0]  ch_ready = '0;
  logic [DW-1:0] ch_data;
  logic [N-1:0]  ch_done = '0;
  logic          busy, all_done, err_underflow;

  hier_fanout_node #(.NUM_CHILD(N), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .up_data(up_data), .up_bcast(up_bcast), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .ch_data(ch_data), .ch_done(ch_done), .busy(busy),
    .all_done(all_done), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int          m_cnt[N];
  bit          m_disp;
  bit [N-1:0]  m_mask;
  int          m_rr;
  bit [DW-1:0] m_data;
  bit          m_err;
  bit          m_busy_prev;
  bit          last_acc;
  int          done_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_disp = 0; m_mask = '0; m_rr = 0; m_data = '0; m_err = 0; m_busy_prev = 0;
  endtask

  // Entered at a falling edge; drives inputs, checks outputs, advances one cycle.
  task automatic step(input bit v, input bit b, input logic [DW-1:0] d,
                      input bit [N-1:0] rdy, input bit [N-1:0] dn);
    bit          all_el, any_el, e_ready, e_busy, e_alldone, n_disp, n_err;
    bit [N-1:0]  e_valid, n_mask;
    bit [DW-1:0] n_data;
    int          n_cnt[N];
    int          n_rr, sel;
    up_valid = v; up_bcast = b; up_data = d; ch_ready = rdy; ch_done = dn;
    #1;
    all_el = 1; any_el = 0; e_busy = m_disp;
    foreach (m_cnt[i]) begin
      if (m_cnt[i] < MO) any_el = 1; else all_el = 0;
      if (m_cnt[i] != 0) e_busy = 1;
    end
    e_ready   = !m_disp && (b ? all_el : any_el);
    e_valid   = m_disp ? m_mask : '0;
    e_alldone = m_busy_prev && !e_busy;
    check("up_ready", up_ready, e_ready);
    check("ch_valid", ch_valid, e_valid);
    check("ch_data", ch_data, m_data);
    check("busy", busy, e_busy);
    check("all_done", all_done, e_alldone);
    check("err_underflow", err_underflow, m_err);
    if (all_done === 1'b1) done_pulses++;

    n_err = m_err;
    foreach (m_cnt[i]) begin
      n_cnt[i] = m_cnt[i] + ((e_valid[i] && rdy[i]) ? 1 : 0);
      if (dn[i]) begin
        if (m_cnt[i] == 0) n_err = 1;
        else n_cnt[i] = n_cnt[i] - 1;
      end
    end
    n_disp = m_disp; n_mask = m_mask; n_rr = m_rr; n_data = m_data;
    last_acc = v && e_ready;
    if (last_acc) begin
      n_data = d;
      n_disp = 1;
      if (b) begin
        n_mask = '1;
      end else begin
        sel = -1;
        for (int k = 0; k < N; k++)
          if (sel < 0 && m_cnt[(m_rr + k) % N] < MO) sel = (m_rr + k) % N;
        n_mask = '0;
        n_mask[sel] = 1'b1;
        n_rr = (sel + 1) % N;
      end
    end else if (m_disp) begin
      n_mask = m_mask & ~rdy;
      if (n_mask == '0) n_disp = 0;
    end
    @(posedge clk);
    foreach (m_cnt[i]) m_cnt[i] = n_cnt[i];
    m_disp = n_disp; m_mask = n_mask; m_rr = n_rr; m_data = n_data;
    m_err = n_err; m_busy_prev = e_busy;
    @(negedge clk);
  endtask

  task automatic send(input bit b, input logic [DW-1:0] d);
    int t;
    t = 0;
    do begin step(1, b, d, '1, '0); t++; end while (!last_acc && t < 20);
    check("accept_in_bound", {31'b0, last_acc}, 32'd1);
    t = 0;
    while (m_disp && t < 20) begin step(0, 0, '0, '1, '0); t++; end
    check("dispatch_ends", ch_valid, '0);
  endtask

  task automatic drain();
    bit [N-1:0] dn;
    for (int t = 0; t < 20; t++) begin
      dn = '0;
      foreach (m_cnt[i]) dn[i] = (m_cnt[i] > 0);
      if (dn == '0) break;
      step(0, 0, '0, '1, dn);
    end
    step(0, 0, '0, '1, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ch_valid"}, ch_valid, '0);
    check({tag, "_ch_data"}, ch_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_all_done"}, all_done, 1'b0);
    check({tag, "_err"}, err_underflow, 1'b0);
  endtask

  initial begin
    bit [N-1:0] dn, rdy;
    model_reset();
    done_pulses = 0;
    @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Six unicasts: children 0,1,2,3,4,0; rr ends at 1
    for (int k = 0; k < 6; k++) send(0, 16'h00A1 + 16'(k));
    step(0, 0, '0, '1, '0);
    drain();

    // Broadcast with child 2 stalled for three cycles; new upstream held off
    step(1, 1, 16'h1234, '1, '0);
    for (int k = 0; k < 3; k++) step(1, 0, 16'h5555, 5'b11011, '0);
    step(1, 0, 16'h5555, '1, '0);
    step(0, 0, 16'h5555, '1, '0);
    drain();

    // Child 1 saturated: unicast skips to child 2, broadcast waits for done[1]
    for (int k = 0; k < 4; k++) send(1, 16'hB000 + 16'(k));
    for (int k = 0; k < 4; k++) step(0, 0, '0, '1, 5'b11101);
    send(0, 16'hC001);
    for (int k = 0; k < 4; k++) step(1, 1, 16'hC002, '1, '0);
    step(1, 1, 16'hC002, '1, 5'b00010);
    send(1, 16'hC002);
    drain();

    // Simultaneous issue and done on child 0, then underflow on child 3
    send(1, 16'hD001);
    send(1, 16'hD002);
    step(1, 1, 16'hD003, '1, '0);
    step(0, 0, '0, '1, 5'b00001);
    drain();
    step(0, 0, '0, '1, 5'b01000);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, '1, '0);
      check("err_sticky", err_underflow, 1'b1);
    end

    // Reset mid-dispatch with three outstanding
    drain();
    for (int k = 0; k < 3; k++) send(0, 16'hE001 + 16'(k));
    step(1, 0, 16'hE004, '1, '0);
    step(0, 0, '0, '0, '0);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    done_pulses = 0;
    send(0, 16'hE005);
    drain();
    for (int k = 0; k < 3; k++) step(0, 0, '0, '1, '0);
    check("all_done_count", done_pulses, 1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      foreach (m_cnt[i]) begin
        rdy[i] = ($urandom_range(0, 3) != 0);
        dn[i]  = (m_cnt[i] > 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 63) == 0);
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           DW'($urandom), rdy, dn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hier_fanout_node.md
HIER_FANOUT_NODE -- requirements
Module: hier_fanout_node

Interface
REQ-001 SHALL have parameter NUM_CHILD, default 5, giving the number of child channels (range 1..16).
REQ-002 SHALL have parameter DATA_W, default 16, giving the command payload width.
REQ-003 SHALL have parameter MAX_OUT, default 4, giving the per-child outstanding-command limit (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port up_valid, input, 1, upstream command valid.
REQ-007 SHALL have port up_ready, output, 1, upstream command accepted when high with up_valid.
REQ-008 SHALL have port up_data, input, DATA_W, upstream command payload.
REQ-009 SHALL have port up_bcast, input, 1, where 1 means broadcast to all children and 0 means unicast round-robin.
REQ-010 SHALL have port ch_valid, output, NUM_CHILD, per-child command valid.
REQ-011 SHALL have port ch_ready, input, NUM_CHILD, per-child command ready.
REQ-012 SHALL have port ch_data, output, DATA_W, shared payload to all children.
REQ-013 SHALL have port ch_done, input, NUM_CHILD, per-child single-cycle completion pulse.
REQ-014 SHALL have port busy, output, 1, high while any command is held or outstanding.
REQ-015 SHALL have port all_done, output, 1, a one-cycle pulse when the node drains completely.
REQ-016 SHALL have port err_underflow, output, 1, a sticky flag for ch_done received with zero outstanding.

Function
REQ-017 SHALL implement FSM states IDLE and DISPATCH.
REQ-018 In IDLE, up_ready SHALL be high only when the eligibility rule is met: broadcast needs every child outstanding < MAX_OUT; unicast needs at least one such child.
REQ-019 On up_valid&&up_ready, the node SHALL register up_data into ch_data, form target mask, and go to DISPATCH next cycle.
- Broadcast mask: all ones.
- Unicast mask: one-hot, first eligible child at or after the rr pointer, with wrap from NUM_CHILD-1 to 0.
REQ-020 In DISPATCH, ch_valid SHALL equal the mask, and ch_data SHALL hold stable.
REQ-021 Each ch_valid[i]&&ch_ready[i] SHALL clear mask[i] and increment outstanding[i].
REQ-022 When the mask becomes zero, the node SHALL return to IDLE.
- No combinational ready-to-valid path.
- Minimum command-to-command spacing is 2 cycles.
REQ-023 Unicast acceptance SHALL set the rr pointer to the selected child + 1 (mod NUM_CHILD); broadcast leaves it unchanged.
REQ-024 ch_done[i] SHALL decrement outstanding[i].
- Issue and done on the same child in the same cycle leave it unchanged.
- Done at zero is ignored and sets err_underflow.
REQ-025 outstanding counters SHALL be $clog2(MAX_OUT+1) bits wide and SHALL never exceed MAX_OUT or wrap.
REQ-026 busy SHALL equal (state==DISPATCH) || (any outstanding != 0).
REQ-027 all_done SHALL pulse the cycle after busy falls 1->0, never otherwise.
REQ-028 up_valid deasserting in IDLE before acceptance SHALL have no effect.

Reset
REQ-029 Asserting rst_n low SHALL, asynchronously and at any time including mid-DISPATCH, force the following:
- state IDLE, mask 0, rr pointer 0, all outstanding 0
- ch_valid 0, ch_data 0, busy 0, all_done 0, err_underflow 0
- up_ready evaluates high once reset is released.
REQ-030 Held commands SHALL be discarded by reset, not replayed.

Structure
REQ-031 A shared package hier_node_pkg SHALL hold the FSM state enum and default-parameter constants.
REQ-032 The per-child counter SHALL be a sub-module hier_credit_ctr (inc, dec, count, at_max, at_zero, underflow), generated NUM_CHILD times.

Verification
REQ-033 Reset release then unicast up_data=0x00A1..0x00A6 with all ch_ready=1 -> children 0,1,2,3,4,0 each receive one command; rr pointer ends at 1.
REQ-034 Broadcast 0x1234 with ch_ready[2]=0 for 3 cycles -> ch_valid[2] holds 3 cycles, ch_data=0x1234 stable, up_ready low until return to IDLE.
REQ-035 Child 1 at outstanding=4 (MAX_OUT), unicast with rr=1 -> child 2 is selected; broadcast -> up_ready stays 0 until ch_done[1].
REQ-036 Simultaneous ch_valid&ch_ready[0] and ch_done[0] at outstanding=2 -> outstanding stays 2; ch_done[3] at 0 -> err_underflow=1, sticky.
REQ-037 rst_n low mid-DISPATCH with 3 outstanding -> all outputs zero immediately; no all_done pulse; after release, one command and its done -> a single all_done pulse.
